axi_lite_multiport_arbiter: RTL

- Parametrised successor to the core's single-master memory arbiter. Arbitrates NUM_PORTS independent requesters onto one AXI4-lite master interface.
- Typical requesters: instruction fetch, load/store, debug/DMA.
- Supports fixed-priority or round-robin grant, a valid/ready request handshake with internal latching, and per-transaction error reporting.
- One AXI transaction is in flight at a time.

---
 rtl/axi_lite_multiport_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/axi_lite_multiport_arbiter.sv
// axi_lite_multiport_arbiter: arbitrates NUM_PORTS valid/ready requesters (req_*/rsp_*) onto one AXI4-lite master (M_AXI_*), CLK rising edge, RST sync active-high
module axi_lite_multiport_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE = 1,
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]             M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]             M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]           M_AXI_WSTRB,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]             M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]             M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, AR, R, AW_W, AW, W, B} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, g, win;
  logic found, grant, done, unused;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [SW-1:0] wstrb;
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = ARB_MODE != 0 ? int'(ptr) + k : k;
      j = j >= NUM_PORTS ? j - NUM_PORTS : j;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
  end
  assign grant = !RST && state == IDLE && rsp_valid == '0 && found;
  assign req_ready = grant ? NUM_PORTS'(1) << win : '0;
  assign done = (state == R && M_AXI_RVALID) || (state == B && M_AXI_BVALID);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = grant ? (req_write[win] ? AW_W : AR) : IDLE;
      AR: state_nx = M_AXI_ARREADY ? R : AR;
      R: state_nx = M_AXI_RVALID ? IDLE : R;
      AW_W: state_nx = M_AXI_AWREADY && M_AXI_WREADY ? B : M_AXI_AWREADY ? W : M_AXI_WREADY ? AW : AW_W;
      AW: state_nx = M_AXI_AWREADY ? B : AW;
      W: state_nx = M_AXI_WREADY ? B : W;
      B: state_nx = M_AXI_BVALID ? IDLE : B;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      rsp_valid <= done ? NUM_PORTS'(1) << g : '0;
      if (grant) begin
        g <= win;
        ptr <= int'(win) == NUM_PORTS - 1 ? '0 : win + 1'b1;
        addr <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        wdata <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
        wstrb <= req_wstrb[win*SW +: SW];
      end
      if (done) begin
        rsp_rdata <= state == R ? M_AXI_RDATA : '0;
        rsp_err <= state == R ? M_AXI_RRESP[1] : M_AXI_BRESP[1];
      end
    end
  end
  assign M_AXI_ARVALID = state == AR;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_ARPROT = AXI_PROT;
  assign M_AXI_RREADY = state == R;
  assign M_AXI_AWVALID = state == AW_W || state == AW;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_AWPROT = AXI_PROT;
  assign M_AXI_WVALID = state == AW_W || state == W;
  assign M_AXI_WDATA = wdata;
  assign M_AXI_WSTRB = wstrb;
  assign M_AXI_BREADY = state == B;
  assign unused = ^{M_AXI_RRESP[0], M_AXI_BRESP[0]};
endmodule
